// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Issues one word-aligned request at a time to instruction memory, buffers
// returned words with their addresses in a 2-entry FIFO for decode, and
// handles taken-branch redirects by flushing the buffer and discarding any
// response that belongs to the old instruction stream.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,

    // instruction memory side
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,

    // redirect from the PC-update path
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,

    // decode side
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_WAIT         = 2'd1,
        S_WAIT_DISCARD = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [31:0] fetch_pc_q;
    logic [31:0] fetch_pc_d;
    logic [31:0] addr_q;
    logic [31:0] addr_d;

    // FIFO storage and bookkeeping
    logic [31:0] fifo_instr_q [2];
    logic [31:0] fifo_pc_q    [2];
    logic        rd_ptr_q;
    logic        wr_ptr_q;
    logic [1:0]  count_q;
    logic [1:0]  count_after_pop;

    logic        push;
    logic        pop;

    // Decode-side view of the FIFO head
    assign instr_valid = (count_q != 2'd0);
    assign instr       = fifo_instr_q[rd_ptr_q];
    assign instr_pc    = fifo_pc_q[rd_ptr_q];

    // A redirect wins over a same-cycle consume; popping an empty FIFO is a no-op
    assign pop             = instr_valid && instr_ready && !redirect_valid;
    assign count_after_pop = count_q - {1'b0, pop};

    // The request is held from the issue edge until the ack edge
    assign imem_req  = (state_q != S_IDLE);
    assign imem_addr = addr_q;

    // Fetch state, current fetch PC and held request address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    // Next-state, request issue, push decision and fetch-PC update
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        push       = 1'b0;

        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end

        case (state_q)
            S_IDLE: begin
                // Issue only if the response is guaranteed a free slot;
                // a redirect this cycle defers the issue to the next cycle.
                if (!redirect_valid && (count_after_pop <= 2'd1)) begin
                    addr_d  = fetch_pc_q;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    state_d = S_IDLE;
                    if (!redirect_valid) begin
                        push       = 1'b1;
                        fetch_pc_d = addr_q + 32'd4;
                    end
                end else if (redirect_valid) begin
                    state_d = S_WAIT_DISCARD;
                end
            end
            S_WAIT_DISCARD: begin
                // Stale response: drop it, fetch PC already holds the redirect target
                if (imem_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO storage: flush on redirect, otherwise push/pop with count tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_instr_q[i] <= '0;
                fifo_pc_q[i]    <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
        end else if (redirect_valid) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_instr_q[wr_ptr_q] <= imem_rdata;
                fifo_pc_q[wr_ptr_q]    <= addr_q;
                wr_ptr_q               <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Occupancy invariants that the issue rule is expected to guarantee
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count_q == 2'd2)));
    a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
        count_q != 2'd3);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized traffic for fetch_unit,
// checked against a transaction-level model (outstanding request, expected
// next fetch address, queue of buffered {instr, pc} entries).
module tb_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b1;

    // main instance (RESET_PC = 0)
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    // wrap-around instance (RESET_PC = 0xFFFF_FFFC), zero-wait, always ready
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack = 1'b0;
    logic [31:0] w_rdata = '0;
    logic        w_redirect_valid = 1'b0;
    logic [31:0] w_redirect_pc = '0;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_instr_pc;
    logic        w_ready = 1'b1;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (w_req),
        .imem_addr      (w_addr),
        .imem_ack       (w_ack),
        .imem_rdata     (w_rdata),
        .redirect_valid (w_redirect_valid),
        .redirect_pc    (w_redirect_pc),
        .instr_valid    (w_valid),
        .instr          (w_instr),
        .instr_pc       (w_instr_pc),
        .instr_ready    (w_ready)
    );

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
    } ent_t;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // reference model
    ent_t        mq[$];
    bit          m_out;
    bit          m_discard;
    logic [31:0] m_addr;
    logic [31:0] m_fetch;

    // observation logs
    logic [31:0] issue_log[$];
    int          issue_cyc[$];
    logic [31:0] pc_log[$];
    logic [31:0] data_log[$];
    logic [31:0] w_issue_log[$];
    logic [31:0] w_pc_log[$];
    logic [31:0] w_data_log[$];
    bit          req_prev;
    bit          w_req_prev;
    int          cyc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] get(input logic [31:0] qq[$], input int unsigned i);
        return (qq.size() > i) ? qq[i] : 32'hBAD0_BAD0;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called at a falling edge; asserts reset asynchronously and releases at a later falling edge
    task automatic do_reset(input bit ack_during);
        imem_ack       = ack_during;
        imem_rdata     = $urandom;
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        w_ack          = ack_during;
        rst_n          = 1'b0;
        #1;
        check_eq("rst_imem_req",    imem_req,    0);
        check_eq("rst_imem_addr",   imem_addr,   32'h0);
        check_eq("rst_instr_valid", instr_valid, 0);
        check_eq("rst_instr",       instr,       32'h0);
        check_eq("rst_instr_pc",    instr_pc,    32'h0);
        check_eq("rst_w_req",       w_req,       0);
        check_eq("rst_w_addr",      w_addr,      32'hFFFF_FFFC);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        imem_ack = 1'b0;
        w_ack    = 1'b0;
        mq.delete();
        m_out     = 1'b0;
        m_discard = 1'b0;
        m_addr    = 32'h0;
        m_fetch   = 32'h0;
        issue_log.delete();
        issue_cyc.delete();
        pc_log.delete();
        data_log.delete();
        w_issue_log.delete();
        w_pc_log.delete();
        w_data_log.delete();
        req_prev   = 1'b0;
        w_req_prev = 1'b0;
        cyc        = 0;
    endtask

    // One clock: check outputs against the model, drive inputs, advance the model
    task automatic cycle(input bit ack_i, input bit ready_i, input bit redir_i, input logic [31:0] rpc_i);
        bit   ack_eff;
        bit   acked;
        bit   popm;
        ent_t e;

        check_eq("imem_req", imem_req, m_out);
        if (m_out) check_eq("imem_addr", imem_addr, m_addr);
        check_eq("instr_valid", instr_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            check_eq("instr",    instr,    mq[0].ins);
            check_eq("instr_pc", instr_pc, mq[0].pc);
        end

        if (imem_req && !req_prev) begin
            issue_log.push_back(imem_addr);
            issue_cyc.push_back(cyc);
        end
        req_prev = imem_req;
        if (instr_valid && ready_i && !redir_i) begin
            pc_log.push_back(instr_pc);
            data_log.push_back(instr);
        end

        ack_eff        = ack_i && imem_req;
        imem_ack       = ack_eff;
        imem_rdata     = ack_eff ? mem_word(imem_addr) : $urandom;
        instr_ready    = ready_i;
        redirect_valid = redir_i;
        redirect_pc    = rpc_i;

        if (w_req && !w_req_prev) w_issue_log.push_back(w_addr);
        w_req_prev = w_req;
        if (w_valid) begin
            w_pc_log.push_back(w_instr_pc);
            w_data_log.push_back(w_instr);
        end
        w_ack   = w_req;
        w_rdata = mem_word(w_addr);
        w_ready = 1'b1;

        // model: consume, redirect, then response or new request
        popm  = (mq.size() != 0) && ready_i && !redir_i;
        acked = m_out && ack_eff;
        if (popm) void'(mq.pop_front());
        if (redir_i) begin
            mq.delete();
            m_fetch = {rpc_i[31:2], 2'b00};
        end
        if (acked) begin
            if (!redir_i && !m_discard) begin
                e.ins = mem_word(m_addr);
                e.pc  = m_addr;
                mq.push_back(e);
                m_fetch = m_addr + 32'd4;
            end
            m_out     = 1'b0;
            m_discard = 1'b0;
        end else if (m_out) begin
            if (redir_i) m_discard = 1'b1;
        end else if (!redir_i && mq.size() <= 1) begin
            m_out     = 1'b1;
            m_addr    = m_fetch;
            m_discard = 1'b0;
        end

        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bit          found;
        int unsigned n8;
        bit          a, r, d;
        logic [31:0] rp;

        @(negedge clk);

        // zero-wait memory, decode always ready
        do_reset(0);
        repeat (8) cycle(1, 1, 0, 0);
        check_eq("t1_issue0", get(issue_log, 0), 32'h0);
        check_eq("t1_issue1", get(issue_log, 1), 32'h4);
        check_eq("t1_issue2", get(issue_log, 2), 32'h8);
        check_eq("t1_first_issue_cycle", (issue_cyc.size() > 0) ? issue_cyc[0] : -1, 1);
        check_eq("t1_gap01", (issue_cyc.size() > 1) ? issue_cyc[1] - issue_cyc[0] : -1, 2);
        check_eq("t1_gap12", (issue_cyc.size() > 2) ? issue_cyc[2] - issue_cyc[1] : -1, 2);
        check_eq("t1_pc0", get(pc_log, 0), 32'h0);
        check_eq("t1_pc1", get(pc_log, 1), 32'h4);
        check_eq("t1_pc2", get(pc_log, 2), 32'h8);
        check_eq("t1_data0", get(data_log, 0), mem_word(32'h0));
        check_eq("t1_data2", get(data_log, 2), mem_word(32'h8));

        // decode stalled: FIFO fills to two, fetching stops, then resumes
        do_reset(0);
        repeat (10) cycle(1, 0, 0, 0);
        check_eq("t2_n_issue", issue_log.size(), 2);
        check_eq("t2_issue1", get(issue_log, 1), 32'h4);
        check_eq("t2_req_low", imem_req, 0);
        check_eq("t2_head_valid", instr_valid, 1);
        check_eq("t2_head_pc", instr_pc, 32'h0);
        repeat (4) cycle(1, 1, 0, 0);
        check_eq("t2_resume", get(issue_log, 2), 32'h8);

        // 3-cycle ack delay with a redirect to 0x100 mid-wait
        do_reset(0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req && imem_addr == 32'h8) begin
                found = 1'b1;
                break;
            end
            cycle(1, 1, 0, 0);
        end
        check_eq("t3_req8_seen", found, 1);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 1, 32'h100);
        cycle(0, 1, 0, 0);
        check_eq("t3_req_held", imem_req, 1);
        check_eq("t3_addr_held", imem_addr, 32'h8);
        cycle(1, 1, 0, 0);
        repeat (6) cycle(1, 1, 0, 0);
        n8 = 0;
        foreach (pc_log[i]) if (pc_log[i] == 32'h8) n8++;
        check_eq("t3_no_0x8_out", n8, 0);
        check_eq("t3_next_issue", get(issue_log, 3), 32'h100);
        check_eq("t3_next_pc", get(pc_log, 2), 32'h100);

        // redirect to 0x203 in the same cycle as an ack, FIFO non-empty
        do_reset(0);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check_eq("t4_valid_before", instr_valid, 1);
        check_eq("t4_req4", imem_addr, 32'h4);
        cycle(1, 0, 1, 32'h203);
        check_eq("t4_flushed", instr_valid, 0);
        check_eq("t4_idle", imem_req, 0);
        cycle(0, 0, 0, 0);
        check_eq("t4_req", imem_req, 1);
        check_eq("t4_addr", imem_addr, 32'h200);
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);

        // wrap-around on the RESET_PC = 0xFFFF_FFFC instance
        do_reset(0);
        repeat (8) cycle(1, 1, 0, 0);
        check_eq("t5_w_issue0", get(w_issue_log, 0), 32'hFFFF_FFFC);
        check_eq("t5_w_issue1", get(w_issue_log, 1), 32'h0);
        check_eq("t5_w_pc0", get(w_pc_log, 0), 32'hFFFF_FFFC);
        check_eq("t5_w_pc1", get(w_pc_log, 1), 32'h0);
        check_eq("t5_w_data0", get(w_data_log, 0), mem_word(32'hFFFF_FFFC));

        // reset pulsed while a request is outstanding and the FIFO holds data
        do_reset(0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 32'h1000);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check_eq("t6_pre_req", imem_req, 1);
        check_eq("t6_pre_addr", imem_addr, 32'h1004);
        check_eq("t6_pre_pc", instr_pc, 32'h1000);
        do_reset(1);
        cycle(0, 1, 0, 0);
        check_eq("t6_first_req", imem_req, 1);
        check_eq("t6_first_addr", imem_addr, 32'h0);

        // randomized traffic
        do_reset(0);
        repeat (3000) begin
            a  = ($urandom_range(0, 99) < 50);
            r  = ($urandom_range(0, 99) < 65);
            d  = ($urandom_range(0, 99) < 6);
            rp = $urandom;
            if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFF0 | {28'h0, rp[3:0]};
            cycle(a, r, d, rp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
